// File: rtl/pic_host_bus_driver.sv
// pic_host_bus_driver: host-side 8259A bus master with automatic INTA acknowledge sequencing
module pic_host_bus_driver #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       int_en,
  input  logic       pic_int,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data,
  output logic [7:0] ack_count,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK1, GAP, ACK2, VEC} state_t;
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic        int_m, int_s, rd_r, a0_r;
  logic [7:0]  data_r;
  logic        ack_start, accept, pulse_end, gap_end;
  assign ack_start = state == IDLE && int_s && int_en && !vec_valid;
  assign cmd_ready = rst_n && state == IDLE && !ack_start;
  assign accept    = cmd_valid && cmd_ready;
  assign pulse_end = cnt == PULSE_LAST;
  assign gap_end   = cnt == GAP_LAST;
  assign cs_n      = !(state == SETUP || state == STROBE || state == HOLD);
  assign rd_n      = !(state == STROBE && rd_r);
  assign wr_n      = !(state == STROBE && !rd_r);
  assign inta_n    = !(state == ACK1 || state == ACK2);
  assign a0        = a0_r;
  assign d_oe      = !cs_n && !rd_r;
  assign d_out     = d_oe ? data_r : 8'd0;
  assign rsp_valid = state == HOLD && rd_r;
  // Two-flop synchronizer for the asynchronous PIC INT line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {int_s, int_m} <= 2'b00;
    else {int_s, int_m} <= {int_m, pic_int};
  // Next state; acknowledge wins over a waiting command in IDLE, cnt restarts on every state change
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = ack_start ? ACK1 : accept ? SETUP : IDLE;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = pulse_end ? HOLD : STROBE;
      HOLD:    state_d = IDLE;
      ACK1:    state_d = pulse_end ? GAP : ACK1;
      GAP:     state_d = gap_end ? ACK2 : GAP;
      ACK2:    state_d = pulse_end ? VEC : ACK2;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d == state ? cnt + 16'd1 : 16'd0;
  end
  // State and phase counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  // Command latch, read/vector capture and vector handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_r      <= 1'b0;
      a0_r      <= 1'b0;
      data_r    <= 8'd0;
      rsp_data  <= 8'd0;
      vec_data  <= 8'd0;
      vec_valid <= 1'b0;
      ack_count <= 8'd0;
    end else begin
      if (accept) {rd_r, a0_r, data_r} <= {cmd_read, cmd_a0, cmd_data};
      if (state == STROBE && pulse_end && rd_r) rsp_data <= d_in;
      if (state == ACK2 && pulse_end) begin
        vec_data  <= d_in;
        vec_valid <= 1'b1;
        ack_count <= ack_count + 8'd1;
      end else if (vec_valid && vec_ready) vec_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pic_host_bus_driver.sv
// tb_pic_host_bus_driver: randomized self-checking bench against a timeline model of the bus cycles
module tb_pic_host_bus_driver;
  localparam int P = 2, G = 1;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_read = 0, cmd_a0 = 0, int_en = 1, pic_int = 0, vec_ready = 0;
  logic [7:0] cmd_data = 0, d_in = 0;
  logic cmd_ready, rsp_valid, vec_valid, cs_n, rd_n, wr_n, inta_n, a0, d_oe;
  logic [7:0] rsp_data, vec_data, ack_count, d_out;
  int checks = 0, failures = 0;
  logic [7:0] exp_ack = 0, exp_rsp = 0;
  logic exp_vv = 0;
  pic_host_bus_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .int_en(int_en), .pic_int(pic_int), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .ack_count(ack_count), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .inta_n(inta_n), .a0(a0), .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );
  always #5 clk = ~clk;

  // One register cycle: SETUP, P strobe cycles, HOLD, checked cycle by cycle
  task automatic do_cmd(input logic rd, input logic ad, input logic [7:0] dat, input logic [7:0] din);
    logic [6:0] got, exp;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready); end
    cmd_valid = 1; cmd_read = rd; cmd_a0 = ad; cmd_data = dat;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_read = 1'($urandom); cmd_a0 = 1'($urandom); cmd_data = 8'($urandom);
    for (int k = 0; k < P + 2; k++) begin
      @(negedge clk);
      d_in = (k == P) ? din : 8'($urandom);
      got = {cs_n, rd_n, wr_n, inta_n, a0, d_oe, rsp_valid};
      exp = {1'b0, !(rd && k >= 1 && k <= P), !(!rd && k >= 1 && k <= P), 1'b1, ad, !rd, rd && k == P + 1};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL cmd_bus k=%0d got=%b exp=%b", k, got, exp); end
      if (!rd) begin
        checks++;
        if (d_out !== dat) begin failures++; $display("FAIL cmd_d_out k=%0d got=%h exp=%h", k, d_out, dat); end
      end
      if (rd && k == P + 1) begin
        checks++;
        if (rsp_data !== din) begin failures++; $display("FAIL rsp_data got=%h exp=%h", rsp_data, din); end
      end
    end
    if (rd) exp_rsp = din;
  endtask

  task automatic idle_check(input int n);
    logic [22:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {cs_n, rd_n, wr_n, inta_n, d_oe, rsp_valid, rsp_data, vec_valid, ack_count};
      exp = {6'b111100, exp_rsp, exp_vv, exp_ack};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL idle got=%h exp=%h", got, exp); end
    end
  endtask

  // Raise pic_int and follow the whole acknowledge up to the VEC cycle
  task automatic do_ack(input logic [7:0] vec, input logic keep_int, input logic hold_cmd, input logic ready_early);
    int ph;
    logic exp_inta;
    @(negedge clk);
    pic_int = 1;
    for (int j = 1; j <= 2 * P + G + 3; j++) begin
      @(negedge clk);
      ph = j - 2;
      if (j == 2 && hold_cmd) begin cmd_valid = 1; cmd_read = 0; cmd_data = 8'($urandom); end
      if (j == 2 && ready_early) vec_ready = 1;
      if (j == 3 && !keep_int) pic_int = 0;
      d_in = (ph == 2 * P + G) ? vec : 8'($urandom);
      exp_inta = !((ph >= 1 && ph <= P) || (ph >= P + G + 1 && ph <= 2 * P + G));
      checks++;
      if ({inta_n, cs_n, d_oe} !== {exp_inta, 2'b10}) begin
        failures++; $display("FAIL ack_bus j=%0d got=%b exp=%b", j, {inta_n, cs_n, d_oe}, {exp_inta, 2'b10});
      end
      if (j >= 2) begin
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ack_cmd_ready j=%0d got=%b exp=0", j, cmd_ready); end
      end
      if (j == 2 * P + G + 3) begin
        checks++;
        if ({vec_valid, vec_data, ack_count} !== {1'b1, vec, exp_ack + 8'd1}) begin
          failures++; $display("FAIL vec got=%b/%h/%0d exp=1/%h/%0d", vec_valid, vec_data, ack_count, vec, exp_ack + 8'd1);
        end
      end
    end
    exp_ack++;
    exp_vv = 1;
    if (ready_early) begin
      @(negedge clk);
      vec_ready = 0;
      checks++;
      if (vec_valid !== 1'b0) begin failures++; $display("FAIL vec_ready_early got=%b exp=0", vec_valid); end
      exp_vv = 0;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    checks++;
    if (vec_valid !== 1'b1) begin failures++; $display("FAIL vec_pending got=%b exp=1", vec_valid); end
    vec_ready = 1;
    @(negedge clk);
    vec_ready = 0;
    checks++;
    if (vec_valid !== 1'b0) begin failures++; $display("FAIL vec_consumed got=%b exp=0", vec_valid); end
    exp_vv = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cs_n, rd_n, wr_n, inta_n, a0, d_oe, rsp_valid, vec_valid, cmd_ready, d_out, rsp_data, vec_data, ack_count}
        !== {4'b1111, 5'b00000, 32'd0}) begin
      failures++; $display("FAIL reset_state cs=%b rd=%b wr=%b inta=%b ready=%b", cs_n, rd_n, wr_n, inta_n, cmd_ready);
    end
    #21 rst_n = 1;
  endtask

  task automatic test_write();
    do_cmd(1'b0, 1'b0, 8'h13, 8'($urandom));
    idle_check(2);
  endtask

  task automatic test_read();
    do_cmd(1'b1, 1'b1, 8'($urandom), 8'hA5);
    idle_check(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) do_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    idle_check(1);
  endtask

  task automatic test_int();
    do_ack(8'h48, 1'b0, 1'b0, 1'b0);
    consume();
    idle_check(2);
  endtask

  task automatic test_contention();
    do_ack(8'($urandom), 1'b0, 1'b1, 1'b0);
    do_cmd(1'b0, 1'b1, 8'h6D, 8'($urandom));
    consume();
    idle_check(1);
  endtask

  task automatic test_vec_hold();
    int n;
    do_ack(8'h21, 1'b1, 1'b0, 1'b0);
    do_cmd(1'b0, 1'b1, 8'h9E, 8'($urandom));
    idle_check(3);
    @(negedge clk);
    vec_ready = 1;
    @(negedge clk);
    vec_ready = 0;
    checks++;
    if ({vec_valid, inta_n, cmd_ready} !== 3'b010) begin
      failures++; $display("FAIL vec_hold_release got=%b exp=010", {vec_valid, inta_n, cmd_ready});
    end
    d_in = 8'h5C;
    pic_int = 0;
    @(negedge clk);
    checks++;
    if (inta_n !== 1'b0) begin failures++; $display("FAIL second_ack_start got=%b exp=0", inta_n); end
    n = 0;
    while (vec_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({vec_valid, vec_data, ack_count} !== {1'b1, 8'h5C, exp_ack + 8'd1}) begin
      failures++; $display("FAIL second_vec got=%b/%h/%0d exp=1/5c/%0d", vec_valid, vec_data, ack_count, exp_ack + 8'd1);
    end
    exp_ack++;
    exp_vv = 1;
    consume();
  endtask

  task automatic test_ready_early();
    do_ack(8'($urandom), 1'b0, 1'b0, 1'b1);
    idle_check(2);
  endtask

  task automatic test_reset_mid();
    logic [7:0] din;
    do_ack(8'h77, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1; cmd_read = 0; cmd_a0 = 1; cmd_data = 8'hC3;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (wr_n !== 1'b0) begin failures++; $display("FAIL pre_reset_strobe got=%b exp=0", wr_n); end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({cs_n, rd_n, wr_n, inta_n, d_oe, a0, vec_valid, cmd_ready, rsp_valid, d_out, rsp_data, vec_data, ack_count}
        !== {9'b111100000, 32'd0}) begin
      failures++; $display("FAIL mid_reset cs=%b wr=%b oe=%b vv=%b cnt=%0d", cs_n, wr_n, d_oe, vec_valid, ack_count);
    end
    exp_ack = 0; exp_vv = 0; exp_rsp = 0;
    @(negedge clk); #2 rst_n = 1;
    do_cmd(1'b0, 1'b1, 8'h3C, 8'($urandom));
    din = 8'($urandom);
    do_cmd(1'b1, 1'b0, 8'($urandom), din);
    idle_check(2);
  endtask

  task automatic test_wrap();
    repeat (256) begin
      do_ack(8'($urandom), 1'b0, 1'b0, 1'b0);
      consume();
    end
    checks++;
    if (ack_count !== 8'd0) begin failures++; $display("FAIL ack_wrap got=%0d exp=0", ack_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      case ($urandom_range(0, 4))
        0, 1: do_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        2: begin do_ack(8'($urandom), 1'b0, 1'b0, 1'b0); consume(); end
        3: do_ack(8'($urandom), 1'b0, 1'b0, 1'b1);
        default: begin
          do_ack(8'($urandom), 1'b0, 1'b1, 1'b0);
          do_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
          consume();
        end
      endcase
    idle_check(2);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_int();
    test_contention();
    test_vec_hold();
    test_ready_early();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
